// File: rtl/tgt_seq.sv
// tgt_seq -- PCI target sequencer for two memory-mapped backends.
//
// Watches BAR hits from the PCI core, qualifies the command, inserts the
// configured number of initial wait states and then paces the data phases.
// It drives the core handshake and the per-backend write strobes and read
// output enables.
//
// Ports
//   CLK            in   1  clock, rising edge
//   reset          in   1  asynchronous, active-high
//   base_hit       in   8  one-cycle BAR hit pulse (bit 0 -> backend 0,
//                          bit 2 -> backend 1, other bits ignored)
//   pci_cmd        in  16  one-hot PCI command
//   s_wrdn         in   1  1 = write transaction
//   s_data         in   1  data phase active
//   s_data_vld     in   1  data word transferred this cycle
//   cfg_wait       in   4  initial wait states (0 = none)
//   cfg_burst_max  in   8  data phases before disconnect (0 = unlimited)
//   s_ready        out  1  target ready (transfer state)
//   s_term         out  1  disconnect request
//   s_abort        out  1  target abort
//   be_wr          out  2  per-backend write strobe
//   be_oe          out  2  per-backend read output enable
//   xfer_cnt       out  8  data phases in the current/last transaction
module tgt_seq (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  base_hit,
  input  logic [15:0] pci_cmd,
  input  logic        s_wrdn,
  input  logic        s_data,
  input  logic        s_data_vld,
  input  logic [3:0]  cfg_wait,
  input  logic [7:0]  cfg_burst_max,
  output logic        s_ready,
  output logic        s_term,
  output logic        s_abort,
  output logic [1:0]  be_wr,
  output logic [1:0]  be_oe,
  output logic [7:0]  xfer_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, ABORT} state_t;

  // MR (6), MW (7), MRM (12), MRL (14), MWI (15)
  localparam logic [15:0] CMD_SUPPORTED = 16'hD0C0;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        dir_q, dir_d;
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  xfer_cnt_q, xfer_cnt_d;

  logic        hit;
  logic        hit_sel;
  logic        cmd_ok;
  logic [7:0]  burst_last;
  logic        hit_unused;

  // Only BARs 0 and 2 map to backends; the remaining hit bits are dropped.
  assign hit_unused = ^{base_hit[7:3], base_hit[1]};
  assign hit        = base_hit[0] | base_hit[2];
  // Backend 0 wins a simultaneous hit.
  assign hit_sel    = ~base_hit[0];
  // At least one supported bit and no unsupported bit; an all-zero command
  // is treated as unsupported.
  assign cmd_ok     = (|(pci_cmd & CMD_SUPPORTED)) & ~(|(pci_cmd & ~CMD_SUPPORTED));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      dir_q      <= 1'b0;
      wait_q     <= 4'd0;
      xfer_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      wait_q     <= wait_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    wait_d     = wait_q;
    xfer_cnt_d = xfer_cnt_q;

    case (state_q)
      IDLE: begin
        if (hit) begin
          if (cmd_ok) begin
            sel_d      = hit_sel;
            dir_d      = s_wrdn;
            xfer_cnt_d = 8'd0;
            if (cfg_wait != 4'd0) begin
              state_d = WAIT;
              wait_d  = cfg_wait;
            end else begin
              state_d = XFER;
            end
          end else begin
            state_d = ABORT;
          end
        end
      end
      WAIT: begin
        if (!s_data) begin
          state_d = IDLE;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q - 4'd1;
          // The counter holds 1 during the last wait cycle.
          if (wait_q <= 4'd1) begin
            state_d = XFER;
            wait_d  = 4'd0;
          end
        end
      end
      XFER: begin
        if (s_data_vld && (xfer_cnt_q != 8'hFF)) begin
          xfer_cnt_d = xfer_cnt_q + 8'd1;
        end
        // xfer_cnt is left holding the final count for software.
        if (!s_data && !s_data_vld) begin
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (!s_data) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Disconnect threshold: asserting one phase early makes the burst end on
  // phase cfg_burst_max. The count is monotonic inside XFER, so s_term stays
  // up until the state is left.
  assign burst_last = cfg_burst_max - 8'd1;

  always_comb begin
    s_ready = (state_q == XFER);
    s_abort = (state_q == ABORT);
    s_term  = (state_q == XFER) && (cfg_burst_max != 8'd0) && (xfer_cnt_q >= burst_last);
    be_wr   = 2'b00;
    be_oe   = 2'b00;
    if ((state_q == XFER) && dir_q && s_data_vld) begin
      be_wr[sel_q] = 1'b1;
    end
    if (((state_q == WAIT) || (state_q == XFER)) && !dir_q && s_data) begin
      be_oe[sel_q] = 1'b1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;

endmodule
